// File: rtl/mem_port_arb_if.sv
// Bundle of requester-side and memory-controller-side signals for mem_port_arb.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_port_arb_if #(
  parameter int NPORT = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [NPORT-1:0]        req;
  logic [NPORT-1:0]        we;
  logic [NPORT*AW-1:0]     p_addr;
  logic [NPORT*DW-1:0]     p_wdata;
  logic [NPORT*DW/8-1:0]   p_wmask;
  logic [NPORT-1:0]        gnt;
  logic [NPORT-1:0]        p_done;
  logic [DW-1:0]           p_rdata;
  logic [1:0]              rw_flag;
  logic [AW-1:0]           addr;
  logic [DW-1:0]           write_data;
  logic [DW/8-1:0]         write_mask;
  logic [DW-1:0]           read_data;
  logic                    busy;
  logic                    done;

  modport master (
    input  req, we, p_addr, p_wdata, p_wmask, read_data, busy, done,
    output gnt, p_done, p_rdata, rw_flag, addr, write_data, write_mask
  );

  modport slave (
    output req, we, p_addr, p_wdata, p_wmask, read_data, busy, done,
    input  gnt, p_done, p_rdata, rw_flag, addr, write_data, write_mask
  );
endinterface

// File: rtl/mem_port_arb.sv
// N-port arbiter onto a single memory-controller channel, one transaction at a time.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module mem_port_arb #(
  parameter int NPORT = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic            CLK,
  input logic            RST,
  mem_port_arb_if.master bus
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NPORT-1:0]  gnt_q, gnt_d;
  logic [NPORT-1:0]  p_done_q, p_done_d;
  logic [DW-1:0]     p_rdata_q, p_rdata_d;
  logic [1:0]        rw_flag_q, rw_flag_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [MW-1:0]     wmask_q, wmask_d;

  logic [PW-1:0]     win_s;
  logic              sel_we_s;
  logic [AW-1:0]     sel_addr_s;
  logic [DW-1:0]     sel_wdata_s;
  logic [MW-1:0]     sel_wmask_s;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic [PW-1:0]     last_q, last_d;
  logic [PW:0]       sum_s;
  logic [PW:0]       idx_s;
  logic              found_s;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 1; k <= NPORT; k++) begin
      sum_s = {1'b0, last_q} + (PW+1)'(k);
      idx_s = (sum_s >= (PW+1)'(NPORT)) ? (sum_s - (PW+1)'(NPORT)) : sum_s;
      if (!found_s && bus.req[idx_s[PW-1:0]]) begin
        win_s   = idx_s[PW-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest requesting index.
  always_comb begin
    win_s = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      win_s = bus.req[i] ? PW'(i) : win_s;
    end
  end
`endif

  // Pick out the winning port's command fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_wmask_s = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (win_s == PW'(i)) begin
        sel_we_s    = bus.we[i];
        sel_addr_s  = bus.p_addr[i*AW +: AW];
        sel_wdata_s = bus.p_wdata[i*DW +: DW];
        sel_wmask_s = bus.p_wmask[i*MW +: MW];
      end else begin
        sel_we_s = sel_we_s;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    p_done_d  = '0;
    p_rdata_d = p_rdata_q;
    rw_flag_d = rw_flag_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.busy && (|bus.req)) begin
          gnt_d     = {{(NPORT-1){1'b0}}, 1'b1} << win_s;
          rw_flag_d = sel_we_s ? 2'b10 : 2'b01;
          addr_d    = sel_addr_s;
          wdata_d   = sel_we_s ? sel_wdata_s : '0;
          wmask_d   = sel_we_s ? sel_wmask_s : '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_d    = win_s;
`endif
          state_d   = ACTIVE;
        end else begin
          gnt_d     = '0;
          rw_flag_d = 2'b00;
          state_d   = IDLE;
        end
      end
      ACTIVE: begin
        if (bus.done) begin
          p_done_d  = gnt_q;
          p_rdata_d = (rw_flag_q == 2'b01) ? bus.read_data : p_rdata_q;
          gnt_d     = '0;
          rw_flag_d = 2'b00;
          state_d   = RECOVER;
        end else begin
          state_d   = ACTIVE;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        gnt_d     = '0;
        rw_flag_d = 2'b00;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      p_done_q  <= '0;
      p_rdata_q <= '0;
      rw_flag_q <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q    <= PW'(NPORT - 1);
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      p_done_q  <= p_done_d;
      p_rdata_q <= p_rdata_d;
      rw_flag_q <= rw_flag_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.p_done     = p_done_q;
  assign bus.p_rdata    = p_rdata_q;
  assign bus.rw_flag    = rw_flag_q;
  assign bus.addr       = addr_q;
  assign bus.write_data = wdata_q;
  assign bus.write_mask = wmask_q;
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb (4 ports, 32-bit address/data).
module tb_mem_port_arb;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_order [5];

  mem_port_arb_if #(.NPORT(4), .AW(32), .DW(32)) bus ();

  mem_port_arb #(.NPORT(4), .AW(32), .DW(32)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.p_addr[i*32 +: 32]  = a;
    bus.p_wdata[i*32 +: 32] = d;
    bus.p_wmask[i*4 +: 4]   = m;
  endtask

  task automatic wait_gnt(input int max_cycles);
    int n;
    n = 0;
    while (bus.gnt == 4'b0000 && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("gnt_wait_in_budget", 64'(n < max_cycles), 64'd1);
  endtask

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    rst            = 1'b0;
    bus.req        = 4'b1111;
    bus.we         = 4'b0000;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.read_data  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      set_port(i, 32'h1000 + 32'(i) * 32'h10, 32'hA0A0_0000 + 32'(i), 4'hF);
    end

    // Reset held with all ports requesting
    tick(); tick(); tick();
    check_eq("rst_gnt", 64'(bus.gnt), 64'h0);
    check_eq("rst_p_done", 64'(bus.p_done), 64'h0);
    check_eq("rst_p_rdata", 64'(bus.p_rdata), 64'h0);
    check_eq("rst_rw_flag", 64'(bus.rw_flag), 64'h0);
    check_eq("rst_addr", 64'(bus.addr), 64'h0);
    check_eq("rst_wdata", 64'(bus.write_data), 64'h0);
    check_eq("rst_wmask", 64'(bus.write_mask), 64'h0);

    rst = 1'b1;
    tick();
    check_eq("first_gnt", 64'(bus.gnt), 64'h1);
    check_eq("first_rw_flag", 64'(bus.rw_flag), 64'h1);
    check_eq("first_addr", 64'(bus.addr), 64'h1000);
    check_eq("first_wdata_read", 64'(bus.write_data), 64'h0);

    // Arbitration order with all four ports requesting
    for (int j = 1; j <= 4; j++) begin
      bus.read_data = 32'h5000_0000 + 32'(j);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check_eq("arb_p_done", 64'(bus.p_done), 64'(4'b0001 << exp_order[j-1]));
      check_eq("arb_p_rdata", 64'(bus.p_rdata), 64'(32'h5000_0000 + 32'(j)));
      check_eq("arb_rw_idle", 64'(bus.rw_flag), 64'h0);
      check_eq("arb_gnt_clear", 64'(bus.gnt), 64'h0);
      tick();
      check_eq("arb_recover_gnt", 64'(bus.gnt), 64'h0);
      tick();
      check_eq("arb_next_gnt", 64'(bus.gnt), 64'(4'b0001 << exp_order[j]));
      check_eq("arb_next_addr", 64'(bus.addr), 64'(32'h1000 + 32'(exp_order[j]) * 32'h10));
    end
    bus.req = 4'b0000;
    bus.read_data = 32'h5000_0005;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_eq("arb_last_done", 64'(bus.p_done), 64'h1);

    // Single read with a two-cycle controller
    set_port(2, 32'h100, 32'h0, 4'h0);
    bus.req = 4'b0100;
    wait_gnt(8);
    check_eq("rd_gnt", 64'(bus.gnt), 64'h4);
    check_eq("rd_rw_flag", 64'(bus.rw_flag), 64'h1);
    check_eq("rd_addr", 64'(bus.addr), 64'h100);
    set_port(2, 32'hFFF0, 32'h0, 4'h0);
    tick();
    check_eq("rd_addr_latched", 64'(bus.addr), 64'h100);
    check_eq("rd_no_early_done", 64'(bus.p_done), 64'h0);
    tick();
    bus.read_data = 32'hDEAD_BEEF;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = 4'b0000;
    check_eq("rd_p_done", 64'(bus.p_done), 64'h4);
    check_eq("rd_p_rdata", 64'(bus.p_rdata), 64'hDEAD_BEEF);
    check_eq("rd_rw_idle", 64'(bus.rw_flag), 64'h0);

    // Write on port 1; read data register must not move
    set_port(1, 32'h204, 32'h1234_5678, 4'b0011);
    bus.we  = 4'b0010;
    bus.req = 4'b0010;
    wait_gnt(8);
    check_eq("wr_gnt", 64'(bus.gnt), 64'h2);
    check_eq("wr_rw_flag", 64'(bus.rw_flag), 64'h2);
    check_eq("wr_addr", 64'(bus.addr), 64'h204);
    check_eq("wr_wdata", 64'(bus.write_data), 64'h1234_5678);
    check_eq("wr_wmask", 64'(bus.write_mask), 64'h3);
    set_port(1, 32'h0, 32'h0, 4'h0);
    bus.we = 4'b0000;
    tick();
    check_eq("wr_wdata_stable", 64'(bus.write_data), 64'h1234_5678);
    check_eq("wr_rw_stable", 64'(bus.rw_flag), 64'h2);
    bus.read_data = 32'hCAFE_F00D;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = 4'b0000;
    check_eq("wr_p_done", 64'(bus.p_done), 64'h2);
    check_eq("wr_p_rdata_kept", 64'(bus.p_rdata), 64'hDEAD_BEEF);

    // Busy controller holds off the grant
    tick(); tick();
    bus.busy = 1'b1;
    bus.req  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("busy_no_gnt", 64'(bus.gnt), 64'h0);
    end
    bus.busy = 1'b0;
    tick();
    check_eq("busy_gnt", 64'(bus.gnt), 64'h1);
    check_eq("rd_wdata_zero", 64'(bus.write_data), 64'h0);
    check_eq("rd_wmask_zero", 64'(bus.write_mask), 64'h0);
    bus.read_data = 32'h1111_2222;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req = 4'b0000;
    check_eq("busy_p_done", 64'(bus.p_done), 64'h1);
    check_eq("busy_p_rdata", 64'(bus.p_rdata), 64'h1111_2222);

    // Spurious controller done while idle
    tick(); tick();
    bus.read_data = 32'h9999_9999;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_eq("spur_p_done", 64'(bus.p_done), 64'h0);
    tick();
    check_eq("spur_p_done_late", 64'(bus.p_done), 64'h0);
    check_eq("spur_gnt", 64'(bus.gnt), 64'h0);
    check_eq("spur_p_rdata", 64'(bus.p_rdata), 64'h1111_2222);

    // Request withdrawn mid-transaction still completes
    bus.req = 4'b1000;
    wait_gnt(8);
    check_eq("drop_gnt", 64'(bus.gnt), 64'h8);
    bus.req = 4'b0000;
    tick();
    check_eq("drop_gnt_held", 64'(bus.gnt), 64'h8);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_eq("drop_p_done", 64'(bus.p_done), 64'h8);

    // Reset during an active transaction
    tick(); tick();
    bus.req = 4'b0100;
    wait_gnt(8);
    check_eq("mrst_gnt", 64'(bus.gnt), 64'h4);
    rst = 1'b0;
    bus.req = 4'b0000;
    tick();
    check_eq("mrst_rw_flag", 64'(bus.rw_flag), 64'h0);
    check_eq("mrst_gnt_clear", 64'(bus.gnt), 64'h0);
    check_eq("mrst_p_rdata", 64'(bus.p_rdata), 64'h0);
    rst = 1'b1;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check_eq("mrst_no_done", 64'(bus.p_done), 64'h0);
    tick();
    check_eq("mrst_no_done_late", 64'(bus.p_done), 64'h0);
    check_eq("mrst_idle_gnt", 64'(bus.gnt), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
